// File: rtl/bram_axil_reader_pkg.sv
// Shared definitions for the BRAM-backed AXI4-Lite read-only slave:
// read FSM state encoding and the AXI response codes it returns.
package bram_axil_reader_pkg;

    // Read-path FSM states; one BRAM access per AR transaction.
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } rd_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/bram_axil_reader.sv
// AXI4-Lite read-only slave in front of BRAM port B.
// Reads fetch one 64-bit BRAM word and return the 32-bit lane chosen by
// address bit 2; writes are accepted and always answered with SLVERR.
//
// Handshake rule used on every channel: a transfer happens on a rising
// edge where valid and ready are both high; a source keeps valid and its
// payload stable until that edge, and ready never depends on valid
// combinationally (all ready/valid outputs here are registers).
module bram_axil_reader
    import bram_axil_reader_pkg::*;
#(
    parameter int ADDR_WIDTH      = 16,
    parameter int BRAM_DATA_WIDTH = 64,
    parameter int AXI_DATA_WIDTH  = 32
) (
    input  logic                       axi_clk,
    input  logic                       axi_rst_n,

    input  logic [ADDR_WIDTH-1:0]      s_axil_araddr,
    input  logic                       s_axil_arvalid,
    output logic                       s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s_axil_rdata,
    output logic [1:0]                 s_axil_rresp,
    output logic                       s_axil_rvalid,
    input  logic                       s_axil_rready,

    input  logic [ADDR_WIDTH-1:0]      s_axil_awaddr,
    input  logic                       s_axil_awvalid,
    output logic                       s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]  s_axil_wdata,
    input  logic [3:0]                 s_axil_wstrb,
    input  logic                       s_axil_wvalid,
    output logic                       s_axil_wready,
    output logic [1:0]                 s_axil_bresp,
    output logic                       s_axil_bvalid,
    input  logic                       s_axil_bready,

    output logic                       bram_rst,
    output logic                       bram_en,
    output logic [7:0]                 bram_we,
    output logic [ADDR_WIDTH-1:0]      bram_addr,
    output logic [BRAM_DATA_WIDTH-1:0] bram_din,
    input  logic [BRAM_DATA_WIDTH-1:0] bram_dout
);

    // Read path state
    rd_state_t                 r_state;
    logic                      r_arready;
    logic                      r_rvalid;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [1:0]                r_rresp;
    logic                      r_bram_en;
    logic [ADDR_WIDTH-1:0]     r_bram_addr;
    logic                      r_lane_hi;

    // Write path state
    logic                      r_aw_held;
    logic                      r_w_held;
    logic                      r_awready;
    logic                      r_wready;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;

    logic                      w_ar_hs;
    logic                      w_aw_hs;
    logic                      w_w_hs;
    logic                      w_b_hs;
    logic                      w_aw_next;
    logic                      w_w_next;
    logic                      w_unused_inputs;

    assign w_ar_hs = r_arready & s_axil_arvalid;
    assign w_aw_hs = r_awready & s_axil_awvalid;
    assign w_w_hs  = r_wready  & s_axil_wvalid;
    assign w_b_hs  = r_bvalid  & s_axil_bready;

    // Hold flags as they will be after this edge (before any B completion).
    assign w_aw_next = r_aw_held | w_aw_hs;
    assign w_w_next  = r_w_held  | w_w_hs;

    // Write payload and the byte-offset address bits carry no meaning here.
    assign w_unused_inputs = ^{s_axil_awaddr, s_axil_wdata, s_axil_wstrb,
                               s_axil_araddr[1:0]};

    // Read FSM: accept AR, pulse the BRAM enable, capture the lane, present R.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            r_state     <= ST_IDLE;
            r_arready   <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rdata     <= '0;
            r_rresp     <= RESP_OKAY;
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
            r_lane_hi   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ar_hs) begin
                        r_lane_hi   <= s_axil_araddr[2];
                        r_bram_addr <= {s_axil_araddr[ADDR_WIDTH-1:3], 3'b000};
                        r_bram_en   <= 1'b1;
                        r_arready   <= 1'b0;
                        r_state     <= ST_ISSUE;
                    end else begin
                        r_arready   <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    // BRAM samples enable/address on this edge; data follows.
                    r_bram_en <= 1'b0;
                    r_state   <= ST_CAPTURE;
                end
                ST_CAPTURE: begin
                    r_rdata  <= r_lane_hi ? bram_dout[AXI_DATA_WIDTH +: AXI_DATA_WIDTH]
                                          : bram_dout[0 +: AXI_DATA_WIDTH];
                    r_rresp  <= RESP_OKAY;
                    r_rvalid <= 1'b1;
                    r_state  <= ST_RESP;
                end
                ST_RESP: begin
                    // Re-arm arready here so IDLE can accept on its first cycle.
                    if (s_axil_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
                default: begin
                    r_bram_en <= 1'b0;
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Write path: hold AW and W independently, answer SLVERR once both are in.
    always_ff @(posedge axi_clk or negedge axi_rst_n) begin
        if (!axi_rst_n) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
        end else if (w_b_hs) begin
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
        end else begin
            r_aw_held <= w_aw_next;
            r_w_held  <= w_w_next;
            r_awready <= ~w_aw_next;
            r_wready  <= ~w_w_next;
            r_bvalid  <= w_aw_next & w_w_next;
            if (w_aw_next && w_w_next) begin
                r_bresp <= RESP_SLVERR;
            end
        end
    end

    assign s_axil_arready = r_arready;
    assign s_axil_rvalid  = r_rvalid;
    assign s_axil_rdata   = r_rdata;
    assign s_axil_rresp   = r_rresp;

    assign s_axil_awready = r_awready;
    assign s_axil_wready  = r_wready;
    assign s_axil_bvalid  = r_bvalid;
    assign s_axil_bresp   = r_bresp;

    assign bram_rst  = ~axi_rst_n;
    assign bram_en   = r_bram_en;
    assign bram_addr = r_bram_addr;
    assign bram_we   = 8'h00;
    assign bram_din  = '0;

endmodule

// File: tb/tb_bram_axil_reader.sv
// Directed testbench for bram_axil_reader with a behavioural BRAM whose
// word i holds i*8.
module tb_bram_axil_reader;
    import bram_axil_reader_pkg::*;

    logic        axi_clk;
    logic        axi_rst_n;
    logic [15:0] s_axil_araddr;
    logic        s_axil_arvalid;
    logic        s_axil_arready;
    logic [31:0] s_axil_rdata;
    logic [1:0]  s_axil_rresp;
    logic        s_axil_rvalid;
    logic        s_axil_rready;
    logic [15:0] s_axil_awaddr;
    logic        s_axil_awvalid;
    logic        s_axil_awready;
    logic [31:0] s_axil_wdata;
    logic [3:0]  s_axil_wstrb;
    logic        s_axil_wvalid;
    logic        s_axil_wready;
    logic [1:0]  s_axil_bresp;
    logic        s_axil_bvalid;
    logic        s_axil_bready;
    logic        bram_rst;
    logic        bram_en;
    logic [7:0]  bram_we;
    logic [15:0] bram_addr;
    logic [63:0] bram_din;
    logic [63:0] bram_dout;

    int tests_run;
    int tests_failed;
    bit we_bad;

    logic [63:0] mem [0:8191];

    bram_axil_reader #(
        .ADDR_WIDTH(16), .BRAM_DATA_WIDTH(64), .AXI_DATA_WIDTH(32)
    ) dut (
        .axi_clk(axi_clk), .axi_rst_n(axi_rst_n),
        .s_axil_araddr(s_axil_araddr), .s_axil_arvalid(s_axil_arvalid),
        .s_axil_arready(s_axil_arready), .s_axil_rdata(s_axil_rdata),
        .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
        .s_axil_rready(s_axil_rready), .s_axil_awaddr(s_axil_awaddr),
        .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready),
        .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
        .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready),
        .s_axil_bresp(s_axil_bresp), .s_axil_bvalid(s_axil_bvalid),
        .s_axil_bready(s_axil_bready), .bram_rst(bram_rst), .bram_en(bram_en),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_dout(bram_dout)
    );

    // Clock
    initial axi_clk = 1'b0;
    always #5 axi_clk = ~axi_clk;

    // BRAM model: registered read, one edge after the enable edge
    initial begin
        for (int i = 0; i < 8192; i++) mem[i] = 64'(i) * 64'd8;
        bram_dout = '0;
    end
    always @(posedge axi_clk) begin
        if (bram_en) bram_dout <= mem[bram_addr[15:3]];
    end

    // Any nonzero write enable or write data ever seen is recorded here
    always @(negedge axi_clk) begin
        if (bram_we !== 8'h00 || bram_din !== 64'h0) we_bad = 1'b1;
    end

    // Single read: lat is the edge number (handshake edge = 1) after which
    // rvalid is first seen; en_ok reports a one-cycle enable at the aligned address.
    task automatic read_txn(input logic [15:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat, output bit en_ok);
        int n;
        s_axil_araddr  = addr;
        s_axil_arvalid = 1'b1;
        n = 0;
        while (!s_axil_arready && n < 20) begin
            @(negedge axi_clk);
            n++;
        end
        @(posedge axi_clk);
        #1 s_axil_arvalid = 1'b0;
        lat   = -1;
        en_ok = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge axi_clk);
            if (k == 1 && !(bram_en === 1'b1 && bram_addr === {addr[15:3], 3'b000})) en_ok = 1'b0;
            if (k > 1 && bram_en !== 1'b0) en_ok = 1'b0;
            if (s_axil_rvalid === 1'b1) begin
                lat = k;
                break;
            end
        end
        data = s_axil_rdata;
        resp = s_axil_rresp;
        s_axil_rready = 1'b1;
        @(posedge axi_clk);
        #1 s_axil_rready = 1'b0;
        @(negedge axi_clk);
    endtask

    // Write: W one cycle ahead of AW when w_lead, else both together.
    // lat counts negedges after the last handshake until bvalid.
    task automatic write_txn(input bit w_lead, output logic [1:0] resp, output int lat);
        s_axil_wdata  = 32'hDEAD_BEEF;
        s_axil_wstrb  = 4'hF;
        s_axil_awaddr = 16'h0008;
        s_axil_wvalid = 1'b1;
        if (!w_lead) s_axil_awvalid = 1'b1;
        @(posedge axi_clk);
        #1 s_axil_wvalid = 1'b0;
        s_axil_awvalid = 1'b0;
        if (w_lead) begin
            @(negedge axi_clk);
            s_axil_awvalid = 1'b1;
            @(posedge axi_clk);
            #1 s_axil_awvalid = 1'b0;
        end
        lat  = -1;
        resp = 2'bxx;
        for (int k = 1; k <= 20; k++) begin
            @(negedge axi_clk);
            if (s_axil_bvalid === 1'b1) begin
                lat  = k;
                resp = s_axil_bresp;
                break;
            end
        end
        @(posedge axi_clk);
        @(negedge axi_clk);
    endtask

    task automatic test_reset();
        axi_rst_n = 1'b0;
        #12;
        tests_run++;
        if ({s_axil_arready, s_axil_rvalid, s_axil_bvalid, s_axil_awready, s_axil_wready, bram_en} !== 6'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000000", {s_axil_arready, s_axil_rvalid, s_axil_bvalid, s_axil_awready, s_axil_wready, bram_en});
        end
        tests_run++;
        if ({s_axil_rdata, s_axil_rresp, s_axil_bresp, bram_addr} !== 52'h0) begin
            tests_failed++;
            $display("FAIL reset_data: rdata=%h rresp=%b bresp=%b bram_addr=%h expected all zero", s_axil_rdata, s_axil_rresp, s_axil_bresp, bram_addr);
        end
        tests_run++;
        if (bram_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_bram_rst: got %b expected 1", bram_rst);
        end
        @(negedge axi_clk);
        axi_rst_n = 1'b1;
        @(negedge axi_clk);
        tests_run++;
        if ({s_axil_arready, s_axil_awready, s_axil_wready, bram_rst} !== 4'b1110) begin
            tests_failed++;
            $display("FAIL reset_release: arready/awready/wready/bram_rst got %b expected 1110", {s_axil_arready, s_axil_awready, s_axil_wready, bram_rst});
        end
    endtask

    task automatic test_basic_reads();
        logic [15:0] addrs [4] = '{16'h0008, 16'h000C, 16'hFFF8, 16'hFFFA};
        logic [31:0] exps  [4] = '{32'h0000_0008, 32'h0000_0000, 32'h0000_FFF8, 32'h0000_FFF8};
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        bit          en_ok;
        for (int i = 0; i < 4; i++) begin
            read_txn(addrs[i], d, r, lat, en_ok);
            tests_run++;
            if (d !== exps[i] || r !== RESP_OKAY) begin
                tests_failed++;
                $display("FAIL read_%h: rdata=%h rresp=%b expected %h 00", addrs[i], d, r, exps[i]);
            end
            tests_run++;
            if (lat !== 3) begin
                tests_failed++;
                $display("FAIL read_latency_%h: got %0d expected 3", addrs[i], lat);
            end
            tests_run++;
            if (!en_ok) begin
                tests_failed++;
                $display("FAIL read_bram_en_%h: en/addr pulse wrong, got 0 expected 1", addrs[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] d0;
        int n;
        int lat;
        s_axil_araddr  = 16'h0010;
        s_axil_arvalid = 1'b1;
        n = 0;
        while (!s_axil_arready && n < 20) begin
            @(negedge axi_clk);
            n++;
        end
        @(posedge axi_clk);
        #1 s_axil_arvalid = 1'b0;
        n = 0;
        while (s_axil_rvalid !== 1'b1 && n < 20) begin
            @(negedge axi_clk);
            n++;
        end
        d0 = s_axil_rdata;
        tests_run++;
        if (d0 !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL bp_first_data: got %h expected 00000010", d0);
        end
        // Offer a second read while R is stalled
        s_axil_araddr  = 16'h0008;
        s_axil_arvalid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge axi_clk);
            tests_run++;
            if (s_axil_rvalid !== 1'b1 || s_axil_rdata !== 32'h0000_0010 || s_axil_arready !== 1'b0) begin
                tests_failed++;
                $display("FAIL bp_stall_%0d: rvalid=%b rdata=%h arready=%b expected 1 00000010 0", c, s_axil_rvalid, s_axil_rdata, s_axil_arready);
            end
        end
        s_axil_rready = 1'b1;
        @(posedge axi_clk);
        #1 s_axil_rready = 1'b0;
        @(negedge axi_clk);
        tests_run++;
        if (s_axil_arready !== 1'b1 || s_axil_rvalid !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_rearm: arready=%b rvalid=%b expected 1 0", s_axil_arready, s_axil_rvalid);
        end
        @(posedge axi_clk);
        #1 s_axil_arvalid = 1'b0;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge axi_clk);
            if (s_axil_rvalid === 1'b1) begin
                lat = k;
                break;
            end
        end
        tests_run++;
        if (lat !== 3 || s_axil_rdata !== 32'h0000_0008) begin
            tests_failed++;
            $display("FAIL bp_second_read: lat=%0d rdata=%h expected 3 00000008", lat, s_axil_rdata);
        end
        s_axil_rready = 1'b1;
        @(posedge axi_clk);
        #1 s_axil_rready = 1'b0;
        @(negedge axi_clk);
    endtask

    task automatic test_write();
        logic [1:0]  r;
        int          lat;
        logic [31:0] d;
        logic [1:0]  rr;
        bit          en_ok;
        s_axil_bready = 1'b1;
        write_txn(1'b1, r, lat);
        tests_run++;
        if (r !== RESP_SLVERR || lat !== 1) begin
            tests_failed++;
            $display("FAIL write_w_first: bresp=%b lat=%0d expected 10 1", r, lat);
        end
        tests_run++;
        if ({s_axil_bvalid, s_axil_awready, s_axil_wready} !== 3'b011) begin
            tests_failed++;
            $display("FAIL write_w_first_done: bvalid/awready/wready got %b expected 011", {s_axil_bvalid, s_axil_awready, s_axil_wready});
        end
        write_txn(1'b0, r, lat);
        tests_run++;
        if (r !== RESP_SLVERR || lat !== 1) begin
            tests_failed++;
            $display("FAIL write_same_cycle: bresp=%b lat=%0d expected 10 1", r, lat);
        end
        tests_run++;
        if ({s_axil_bvalid, s_axil_awready, s_axil_wready} !== 3'b011) begin
            tests_failed++;
            $display("FAIL write_same_cycle_done: bvalid/awready/wready got %b expected 011", {s_axil_bvalid, s_axil_awready, s_axil_wready});
        end
        tests_run++;
        if (we_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_bram_untouched: nonzero we/din seen got 1 expected 0");
        end
        read_txn(16'h0008, d, rr, lat, en_ok);
        tests_run++;
        if (d !== 32'h0000_0008 || rr !== RESP_OKAY) begin
            tests_failed++;
            $display("FAIL write_readback: rdata=%h rresp=%b expected 00000008 00", d, rr);
        end
    endtask

    task automatic test_reset_mid();
        int          n;
        int          seen;
        logic [31:0] d;
        logic [1:0]  rr;
        int          lat;
        bit          en_ok;
        // Leave a W hold pending, then start a read and reset in CAPTURE
        s_axil_wvalid = 1'b1;
        @(posedge axi_clk);
        #1 s_axil_wvalid = 1'b0;
        @(negedge axi_clk);
        s_axil_araddr  = 16'h0008;
        s_axil_arvalid = 1'b1;
        n = 0;
        while (!s_axil_arready && n < 20) begin
            @(negedge axi_clk);
            n++;
        end
        @(posedge axi_clk);
        #1 s_axil_arvalid = 1'b0;
        @(posedge axi_clk);
        #2 axi_rst_n = 1'b0;
        #1;
        tests_run++;
        if (dut.r_state !== ST_IDLE || {s_axil_rvalid, s_axil_arready, bram_en} !== 3'b000 || s_axil_rdata !== 32'h0 || bram_rst !== 1'b1) begin
            tests_failed++;
            $display("FAIL midreset_outputs: state=%0d rvalid/arready/en=%b rdata=%h bram_rst=%b expected 0 000 00000000 1",
                     dut.r_state, {s_axil_rvalid, s_axil_arready, bram_en}, s_axil_rdata, bram_rst);
        end
        @(negedge axi_clk);
        @(negedge axi_clk);
        axi_rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge axi_clk);
            if (s_axil_rvalid === 1'b1 || s_axil_bvalid === 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL midreset_no_stale: valid cycles got %0d expected 0", seen);
        end
        // Only AW now: the W hold from before reset must be gone
        s_axil_awvalid = 1'b1;
        @(posedge axi_clk);
        #1 s_axil_awvalid = 1'b0;
        seen = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge axi_clk);
            if (s_axil_bvalid === 1'b1) seen++;
        end
        tests_run++;
        if (seen !== 0) begin
            tests_failed++;
            $display("FAIL midreset_w_hold_cleared: bvalid cycles got %0d expected 0", seen);
        end
        // Complete that write so the write path is idle again
        s_axil_wvalid = 1'b1;
        @(posedge axi_clk);
        #1 s_axil_wvalid = 1'b0;
        @(negedge axi_clk);
        tests_run++;
        if (s_axil_bvalid !== 1'b1 || s_axil_bresp !== RESP_SLVERR) begin
            tests_failed++;
            $display("FAIL midreset_write_completes: bvalid=%b bresp=%b expected 1 10", s_axil_bvalid, s_axil_bresp);
        end
        @(posedge axi_clk);
        @(negedge axi_clk);
        read_txn(16'h0018, d, rr, lat, en_ok);
        tests_run++;
        if (d !== 32'h0000_0018 || rr !== RESP_OKAY || lat !== 3) begin
            tests_failed++;
            $display("FAIL midreset_next_read: rdata=%h rresp=%b lat=%0d expected 00000018 00 3", d, rr, lat);
        end
    endtask

    task automatic test_concurrent();
        int          rlat;
        int          blat;
        logic [31:0] d;
        logic [1:0]  br;
        rlat = -1;
        blat = -1;
        br   = 2'bxx;
        d    = 'x;
        s_axil_bready  = 1'b1;
        s_axil_rready  = 1'b1;
        s_axil_araddr  = 16'h0010;
        s_axil_arvalid = 1'b1;
        s_axil_awvalid = 1'b1;
        s_axil_wvalid  = 1'b1;
        tests_run++;
        if ({s_axil_arready, s_axil_awready, s_axil_wready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL conc_ready: ar/aw/w ready got %b expected 111", {s_axil_arready, s_axil_awready, s_axil_wready});
        end
        @(posedge axi_clk);
        #1;
        s_axil_arvalid = 1'b0;
        s_axil_awvalid = 1'b0;
        s_axil_wvalid  = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge axi_clk);
            if (blat < 0 && s_axil_bvalid === 1'b1) begin
                blat = k;
                br   = s_axil_bresp;
            end
            if (rlat < 0 && s_axil_rvalid === 1'b1) begin
                rlat = k;
                d    = s_axil_rdata;
            end
            if (rlat > 0 && blat > 0) break;
        end
        tests_run++;
        if (rlat !== 3 || d !== 32'h0000_0010) begin
            tests_failed++;
            $display("FAIL conc_read: lat=%0d rdata=%h expected 3 00000010", rlat, d);
        end
        tests_run++;
        if (blat !== 1 || br !== RESP_SLVERR) begin
            tests_failed++;
            $display("FAIL conc_write: lat=%0d bresp=%b expected 1 10", blat, br);
        end
        @(posedge axi_clk);
        #1 s_axil_rready = 1'b0;
        @(negedge axi_clk);
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        we_bad         = 1'b0;
        axi_rst_n      = 1'b0;
        s_axil_araddr  = '0;
        s_axil_arvalid = 1'b0;
        s_axil_rready  = 1'b0;
        s_axil_awaddr  = '0;
        s_axil_awvalid = 1'b0;
        s_axil_wdata   = '0;
        s_axil_wstrb   = '0;
        s_axil_wvalid  = 1'b0;
        s_axil_bready  = 1'b0;

        test_reset();
        test_basic_reads();
        test_backpressure();
        test_write();
        test_reset_mid();
        test_concurrent();

        tests_run++;
        if (we_bad !== 1'b0) begin
            tests_failed++;
            $display("FAIL bram_never_written: nonzero we/din seen got 1 expected 0");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bram_axil_reader.md
BRAM_AXIL_READER -- requirements
Module: bram_axil_reader

Interface
REQ-001 Parameters, one per line:
- ADDR_WIDTH, 16, byte-address width.
- BRAM_DATA_WIDTH, 64, BRAM word width.
- AXI_DATA_WIDTH, 32, AXI4-Lite data width.
REQ-002 Ports, one per line, clock and reset first:
- axi_clk  in  1  single clock for all logic.
- axi_rst_n  in  1  reset, asynchronous, active-low.
- s_axil_araddr  in  ADDR_WIDTH  read byte address.
- s_axil_arvalid / s_axil_arready  in / out  1  read-address handshake.
- s_axil_rdata  out  AXI_DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid / s_axil_rready  out / in  1  read-data handshake.
- s_axil_awaddr  in  ADDR_WIDTH  write address (value ignored).
- s_axil_awvalid / s_axil_awready  in / out  1  write-address handshake.
- s_axil_wdata  in  AXI_DATA_WIDTH  write data (ignored).
- s_axil_wstrb  in  4  write strobes (ignored).
- s_axil_wvalid / s_axil_wready  in / out  1  write-data handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid / s_axil_bready  out / in  1  write-response handshake.
- bram_rst  out  1  active-high reset to BRAM port B.
- bram_en  out  1  BRAM port B enable.
- bram_we  out  8  BRAM port B write enables, constant 0.
- bram_addr  out  ADDR_WIDTH  BRAM port B byte address.
- bram_din  out  BRAM_DATA_WIDTH  constant 0.
- bram_dout  in  BRAM_DATA_WIDTH  BRAM port B read data, valid one edge after the enable edge.

Function
REQ-003 Read FSM states: IDLE, ISSUE, CAPTURE, RESP.
REQ-004 IDLE: arready=1; on arvalid&arready, latch araddr and go to ISSUE. arready=0 in every other state.
REQ-005 ISSUE: bram_en=1; bram_addr = {latched addr[ADDR_WIDTH-1:3], 3'b000}; unconditionally go to CAPTURE. bram_en=0 in all other states.
REQ-006 CAPTURE: register rdata = bram_dout[63:32] if latched addr[2]=1, else bram_dout[31:0]; rresp=2'b00; go to RESP.
REQ-007 RESP: rvalid=1 with rdata and rresp held stable; on rready go to IDLE.
REQ-008 Latency: rvalid rises exactly 3 edges after the AR handshake edge; maximum read throughput is one read per 4 cycles.
REQ-009 addr[1:0] is ignored (unaligned addresses read the containing 32-bit lane with OKAY); all 2^ADDR_WIDTH addresses are in range.
REQ-010 Write path is read-only and rejects all writes:
- awready=1 while no AW is held; wready=1 while no W is held.
- AW and W are accepted in either order or in the same cycle.
- When both are held, assert bvalid with bresp=2'b10 (SLVERR); clear both holds on bvalid&bready.
- The BRAM is never written; bram_we=0 and bram_din=0 at all times.
REQ-011 Read and write paths are independent; simultaneous activity on both does not stall either.
REQ-012 bram_rst = ~axi_rst_n (combinational).

Reset
REQ-013 Asynchronous assertion: FSM=IDLE, all holds cleared, arready=0, rvalid=0, bvalid=0, awready=0, wready=0, rdata=0, rresp=0, bresp=0, bram_en=0, bram_addr=0.
REQ-014 First cycle after deassertion: arready=1, awready=1, wready=1.
REQ-015 Reset asserted mid-transaction aborts it; no stale rvalid or bvalid appears after release.

Structure
REQ-016 Shared package holds the read FSM state enum and the RESP_OKAY=2'b00 and RESP_SLVERR=2'b10 constants.
REQ-017 The block is flat; no sub-module.

Verification
REQ-018 BRAM initialised with word i = i*8; read 0x0008 -> rdata=0x00000008, rresp=OKAY, rvalid 3 edges after the AR handshake.
REQ-019 Read 0x000C -> rdata=0x00000000 (upper lane); read 0xFFF8 -> rdata=0x0000FFF8; read 0xFFFA -> rdata=0x0000FFF8.
REQ-020 rready held low 5 cycles -> rvalid and rdata stable throughout, arready=0; a second arvalid is accepted only after the R handshake.
REQ-021 W one cycle before AW, then AW+W in the same cycle, bready=1 -> bresp=SLVERR for each; bram_we=0 throughout; a subsequent read of 0x0008 still returns 0x00000008.
REQ-022 axi_rst_n pulsed low during CAPTURE -> outputs reset immediately; no rvalid after release; the next read completes normally.
REQ-023 Write sequence and read 0x0010 issued concurrently -> both complete with SLVERR and 0x00000010 respectively, with no added read latency.
